// File: rtl/decode_execute_unit_if.sv
// decode_execute_unit_if
//   Bundles the decode/execute stage's fetch, register-bank and control-word
//   signals. Vectors use [0:N-1] numbering, so index 0 is the MSB.
//   master : fetch/regbank side (drives instruction and rvalue_*, observes the rest)
//   slave  : decode_execute_unit (drives radr_* and all registered outputs)
interface decode_execute_unit_if;
  logic [0:31] instruction;
  logic [0:4]  radr_dest, radr_a, radr_b;
  logic [0:31] rvalue_dest, rvalue_a, rvalue_b;
  logic [0:1]  optype;
  logic [0:2]  deference;
  logic [0:3]  aluop;
  logic [0:5]  shamft;
  logic [0:1]  pcconfig;
  logic        ramconfig;
  logic        regbankconfig;
  logic [0:1]  regsource;
  logic [0:31] dest, opA, opB;
  logic [0:31] result;
  logic        illegal;

  modport master (
    output instruction, rvalue_dest, rvalue_a, rvalue_b,
    input  radr_dest, radr_a, radr_b, optype, deference, aluop, shamft,
           pcconfig, ramconfig, regbankconfig, regsource,
           dest, opA, opB, result, illegal
  );

  modport slave (
    input  instruction, rvalue_dest, rvalue_a, rvalue_b,
    output radr_dest, radr_a, radr_b, optype, deference, aluop, shamft,
           pcconfig, ramconfig, regbankconfig, regsource,
           dest, opA, opB, result, illegal
  );
endinterface

// File: rtl/decode_execute_unit.sv
// decode_execute_unit
//   I-type decode, control-word generation and ALU execute stage.
//   Register-bank read addresses are combinational from the instruction;
//   every other output is captured on the rising clock edge (latency 1).
// Ports
//   clock_i : rising-edge clock
//   reset_i : synchronous active-high reset; clears all output registers (NOP)
//   bus_io  : decode_execute_unit_if.slave
//             in  instruction, rvalue_dest/a/b
//             out radr_dest/a/b (comb), optype, deference, aluop, shamft,
//                 pcconfig, ramconfig, regbankconfig, regsource,
//                 dest, opA, opB, result, illegal (registered)
//   Bit numbering is [0:N-1] with bit 0 = MSB throughout.
module decode_execute_unit (
  input  logic                   clock_i,
  input  logic                   reset_i,
  decode_execute_unit_if.slave   bus_io
);

  // Opcodes
  localparam logic [0:5] OP_NOP  = 6'h00;
  localparam logic [0:5] OP_ADDI = 6'h01;
  localparam logic [0:5] OP_SUBI = 6'h02;
  localparam logic [0:5] OP_ANDI = 6'h03;
  localparam logic [0:5] OP_ORI  = 6'h04;
  localparam logic [0:5] OP_XORI = 6'h05;
  localparam logic [0:5] OP_SLLI = 6'h06;
  localparam logic [0:5] OP_SRLI = 6'h07;
  localparam logic [0:5] OP_SRAI = 6'h08;
  localparam logic [0:5] OP_SLTI = 6'h09;
  localparam logic [0:5] OP_LW   = 6'h0A;
  localparam logic [0:5] OP_SW   = 6'h0B;
  localparam logic [0:5] OP_BEQ  = 6'h0C;
  localparam logic [0:5] OP_BNE  = 6'h0D;
  localparam logic [0:5] OP_JALR = 6'h0E;

  // ALU operation codes
  localparam logic [0:3] ALU_ADD   = 4'd0;
  localparam logic [0:3] ALU_SUB   = 4'd1;
  localparam logic [0:3] ALU_AND   = 4'd2;
  localparam logic [0:3] ALU_OR    = 4'd3;
  localparam logic [0:3] ALU_XOR   = 4'd4;
  localparam logic [0:3] ALU_NOR   = 4'd5;
  localparam logic [0:3] ALU_SLL   = 4'd6;
  localparam logic [0:3] ALU_SRL   = 4'd7;
  localparam logic [0:3] ALU_SRA   = 4'd8;
  localparam logic [0:3] ALU_SLT   = 4'd9;
  localparam logic [0:3] ALU_BEQ   = 4'd10;
  localparam logic [0:3] ALU_BNE   = 4'd11;
  localparam logic [0:3] ALU_PASSA = 4'd12;

  // Deference masks, bit 0 = dest, bit 1 = opA, bit 2 = opB
  localparam logic [0:2] DFR_A  = 3'b010;
  localparam logic [0:2] DFR_DA = 3'b110;

  // pcconfig / regsource encodings
  localparam logic [0:1] PC_REL = 2'b10;  // pc += result
  localparam logic [0:1] PC_ABS = 2'b01;  // pc  = result
  localparam logic [0:1] SRC_RAM = 2'b01;
  localparam logic [0:1] SRC_PC  = 2'b10;

  typedef struct packed {
    logic [0:1] optype;
    logic [0:2] dfr;
    logic [0:3] aluop;
    logic [0:5] shamft;
    logic [0:1] pc;
    logic       ram;
    logic       regw;
    logic [0:1] src;
    logic       illegal;
  } ctrl_t;

  // ---------------------------------------------------------------- decode
  logic [0:5]  opc;
  logic [0:31] vdest, vopa, vopb;

  assign opc   = bus_io.instruction[0:5];
  assign vdest = {27'd0, bus_io.instruction[6:10]};
  assign vopa  = {27'd0, bus_io.instruction[11:15]};
  assign vopb  = {{16{bus_io.instruction[16]}}, bus_io.instruction[16:31]};

  assign bus_io.radr_dest = bus_io.instruction[6:10];
  assign bus_io.radr_a    = bus_io.instruction[11:15];
  assign bus_io.radr_b    = bus_io.instruction[27:31];

  ctrl_t ctrl_d, ctrl_q;

  // '0 is the NOP control word (ADD, no deference, no writes, pc+1), so only
  // the fields that differ from it are set per opcode. Unknown opcodes keep it
  // and only raise illegal.
  always_comb begin
    ctrl_d = '0;
    case (opc)
      OP_NOP: ctrl_d = '0;
      OP_ADDI: begin
        ctrl_d.dfr = DFR_A; ctrl_d.regw = 1'b1; ctrl_d.aluop = ALU_ADD;
      end
      OP_SUBI: begin
        ctrl_d.dfr = DFR_A; ctrl_d.regw = 1'b1; ctrl_d.aluop = ALU_SUB;
      end
      OP_ANDI: begin
        ctrl_d.dfr = DFR_A; ctrl_d.regw = 1'b1; ctrl_d.aluop = ALU_AND;
      end
      OP_ORI: begin
        ctrl_d.dfr = DFR_A; ctrl_d.regw = 1'b1; ctrl_d.aluop = ALU_OR;
      end
      OP_XORI: begin
        ctrl_d.dfr = DFR_A; ctrl_d.regw = 1'b1; ctrl_d.aluop = ALU_XOR;
      end
      OP_SLLI: begin
        ctrl_d.dfr = DFR_A; ctrl_d.regw = 1'b1; ctrl_d.aluop = ALU_SLL;
        ctrl_d.shamft = bus_io.instruction[26:31];
      end
      OP_SRLI: begin
        ctrl_d.dfr = DFR_A; ctrl_d.regw = 1'b1; ctrl_d.aluop = ALU_SRL;
        ctrl_d.shamft = bus_io.instruction[26:31];
      end
      OP_SRAI: begin
        ctrl_d.dfr = DFR_A; ctrl_d.regw = 1'b1; ctrl_d.aluop = ALU_SRA;
        ctrl_d.shamft = bus_io.instruction[26:31];
      end
      OP_SLTI: begin
        ctrl_d.dfr = DFR_A; ctrl_d.regw = 1'b1; ctrl_d.aluop = ALU_SLT;
      end
      OP_LW: begin
        ctrl_d.dfr = DFR_A; ctrl_d.regw = 1'b1; ctrl_d.aluop = ALU_ADD;
        ctrl_d.src = SRC_RAM;
      end
      // Store: address = base + imm, store data comes out on dest.
      OP_SW: begin
        ctrl_d.dfr = DFR_DA; ctrl_d.ram = 1'b1; ctrl_d.aluop = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_d.dfr = DFR_DA; ctrl_d.aluop = ALU_BEQ; ctrl_d.pc = PC_REL;
      end
      OP_BNE: begin
        ctrl_d.dfr = DFR_DA; ctrl_d.aluop = ALU_BNE; ctrl_d.pc = PC_REL;
      end
      OP_JALR: begin
        ctrl_d.dfr = DFR_A; ctrl_d.regw = 1'b1; ctrl_d.aluop = ALU_ADD;
        ctrl_d.pc = PC_ABS; ctrl_d.src = SRC_PC;
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
  end

  // ------------------------------------------------------- operand select
  logic [0:31] dest_d, opa_d, opb_d;

  assign dest_d = ctrl_d.dfr[0] ? bus_io.rvalue_dest : vdest;
  assign opa_d  = ctrl_d.dfr[1] ? bus_io.rvalue_a    : vopa;
  assign opb_d  = ctrl_d.dfr[2] ? bus_io.rvalue_b    : vopb;

  // ------------------------------------------------------------------ ALU
  // opC is the effective dest; branches compare it against opA and yield
  // either the offset (taken) or 1 (fall through) so the PC adder is shared.
  logic [0:31] res_d;
  logic        sh_big;

  assign sh_big = (ctrl_d.shamft >= 6'd32);

  always_comb begin
    res_d = '0;
    case (ctrl_d.aluop)
      ALU_ADD:   res_d = opa_d + opb_d;
      ALU_SUB:   res_d = opa_d - opb_d;
      ALU_AND:   res_d = opa_d & opb_d;
      ALU_OR:    res_d = opa_d | opb_d;
      ALU_XOR:   res_d = opa_d ^ opb_d;
      ALU_NOR:   res_d = ~(opa_d | opb_d);
      ALU_SLL:   res_d = sh_big ? 32'd0 : (opa_d << ctrl_d.shamft);
      ALU_SRL:   res_d = sh_big ? 32'd0 : (opa_d >> ctrl_d.shamft);
      ALU_SRA:   res_d = sh_big ? {32{opa_d[0]}}
                                : 32'($signed(opa_d) >>> ctrl_d.shamft);
      ALU_SLT:   res_d = ($signed(opa_d) < $signed(opb_d)) ? 32'd1 : 32'd0;
      ALU_BEQ:   res_d = (opa_d == dest_d) ? opb_d : 32'd1;
      ALU_BNE:   res_d = (opa_d != dest_d) ? opb_d : 32'd1;
      ALU_PASSA: res_d = opa_d;
      default:   res_d = '0;
    endcase
  end

  // ------------------------------------------------------ output registers
  logic [0:31] dest_q, opa_q, opb_q, res_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ctrl_q <= '0;
      dest_q <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      res_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      dest_q <= dest_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      res_q  <= res_d;
    end
  end

  assign bus_io.optype        = ctrl_q.optype;
  assign bus_io.deference     = ctrl_q.dfr;
  assign bus_io.aluop         = ctrl_q.aluop;
  assign bus_io.shamft        = ctrl_q.shamft;
  assign bus_io.pcconfig      = ctrl_q.pc;
  assign bus_io.ramconfig     = ctrl_q.ram;
  assign bus_io.regbankconfig = ctrl_q.regw;
  assign bus_io.regsource     = ctrl_q.src;
  assign bus_io.illegal       = ctrl_q.illegal;
  assign bus_io.dest          = dest_q;
  assign bus_io.opA           = opa_q;
  assign bus_io.opB           = opb_q;
  assign bus_io.result        = res_q;

endmodule

// File: tb/tb_decode_execute_unit.sv
module tb_decode_execute_unit;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  decode_execute_unit_if bus();
  decode_execute_unit dut (.clock_i(clock), .reset_i(reset), .bus_io(bus));

  int checks = 0;
  int errors = 0;

  // Expected outputs; dfr packed as {use_dest, use_opA, use_opB}.
  typedef struct packed {
    logic [31:0] dest, opa, opb, res;
    logic [3:0]  alu;
    logic [2:0]  dfr;
    logic [5:0]  sh;
    logic [1:0]  pc;
    logic        ram, regw;
    logic [1:0]  src;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins, rvd, rva, rvb, res;
    logic        regw;
    logic [1:0]  pc;
    logic        ill;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int opc, input int rd, input int rs, input int imm);
    logic [5:0] o; logic [4:0] d; logic [4:0] s; logic [15:0] i;
    o = opc[5:0]; d = rd[4:0]; s = rs[4:0]; i = imm[15:0];
    return {o, d, s, i};
  endfunction

  // Reference model: control table per opcode, then operand selection and
  // arithmetic done on 64-bit integers with explicit modulo 2^32.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rvd,
                                 input logic [31:0] rva, input logic [31:0] rvb);
    exp_t e;
    int opc;
    longint M, a, b, c, sa, sb, p, q;
    int sh;
    logic [31:0] sx;
    e = '0;
    M = 64'sh1_0000_0000;
    opc = int'(ins[31:26]);
    case (opc)
      0: ;
      1,2,3,4,5,6,7,8,9,10,14: begin e.dfr = 3'b010; e.regw = 1'b1; end
      11,12,13: e.dfr = 3'b110;
      default: e.ill = 1'b1;
    endcase
    case (opc)
      2: e.alu = 1;  3: e.alu = 2;  4: e.alu = 3;  5: e.alu = 4;
      6: e.alu = 6;  7: e.alu = 7;  8: e.alu = 8;  9: e.alu = 9;
      12: e.alu = 10; 13: e.alu = 11;
      default: e.alu = 0;
    endcase
    if (opc >= 6 && opc <= 8) e.sh = ins[5:0];
    if (opc == 10) e.src = 2'b01;
    if (opc == 11) begin e.ram = 1'b1; e.regw = 1'b0; end
    if (opc == 12 || opc == 13) e.pc = 2'b10;
    if (opc == 14) begin e.pc = 2'b01; e.src = 2'b10; end

    sx = {{16{ins[15]}}, ins[15:0]};
    e.dest = e.dfr[2] ? rvd : {27'd0, ins[25:21]};
    e.opa  = e.dfr[1] ? rva : {27'd0, ins[20:16]};
    e.opb  = e.dfr[0] ? rvb : sx;

    a = longint'({32'd0, e.opa}); b = longint'({32'd0, e.opb});
    c = longint'({32'd0, e.dest});
    sa = (a >= M/2) ? a - M : a;
    sb = (b >= M/2) ? b - M : b;
    sh = int'(e.sh);
    case (e.alu)
      0: q = (a + b) % M;
      1: q = (a + M - b) % M;
      2: q = a & b;
      3: q = a | b;
      4: q = a ^ b;
      6: q = (sh >= 32) ? 0 : (a * (64'sd1 << sh)) % M;
      7: q = (sh >= 32) ? 0 : a / (64'sd1 << sh);
      8: begin
        if (sh >= 32) q = (sa < 0) ? M - 1 : 0;
        else begin
          p = 64'sd1 << sh;
          q = sa / p;
          if (sa < 0 && (sa % p) != 0) q = q - 1;   // floor division
          q = (q + M) % M;
        end
      end
      9: q = (sa < sb) ? 1 : 0;
      10: q = (a == c) ? b : 1;
      11: q = (a != c) ? b : 1;
      default: q = 0;
    endcase
    e.res = q[31:0];
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".result"}, bus.result, e.res);
    chk({tag, ".dest"}, bus.dest, e.dest);
    chk({tag, ".opA"}, bus.opA, e.opa);
    chk({tag, ".opB"}, bus.opB, e.opb);
    chk({tag, ".aluop"}, {28'd0, bus.aluop}, {28'd0, e.alu});
    chk({tag, ".deference"}, {29'd0, bus.deference[0], bus.deference[1], bus.deference[2]},
        {29'd0, e.dfr});
    chk({tag, ".shamft"}, {26'd0, bus.shamft}, {26'd0, e.sh});
    chk({tag, ".pcconfig"}, {30'd0, bus.pcconfig}, {30'd0, e.pc});
    chk({tag, ".ramconfig"}, {31'd0, bus.ramconfig}, {31'd0, e.ram});
    chk({tag, ".regbankconfig"}, {31'd0, bus.regbankconfig}, {31'd0, e.regw});
    chk({tag, ".regsource"}, {30'd0, bus.regsource}, {30'd0, e.src});
    chk({tag, ".optype"}, {30'd0, bus.optype}, 32'd0);
    chk({tag, ".illegal"}, {31'd0, bus.illegal}, {31'd0, e.ill});
  endtask

  // Drive one cycle's inputs just after a rising edge, check the
  // combinational read addresses, then step to 1 time unit after the next edge.
  task automatic apply(input logic [31:0] ins, input logic [31:0] rvd,
                       input logic [31:0] rva, input logic [31:0] rvb, input logic rst);
    bus.instruction = ins;
    bus.rvalue_dest = rvd;
    bus.rvalue_a    = rva;
    bus.rvalue_b    = rvb;
    reset           = rst;
    #1;
    chk("radr_dest", {27'd0, bus.radr_dest}, {27'd0, ins[25:21]});
    chk("radr_a",    {27'd0, bus.radr_a},    {27'd0, ins[20:16]});
    chk("radr_b",    {27'd0, bus.radr_b},    {27'd0, ins[4:0]});
    @(posedge clock);
    #1;
  endtask

  vec_t vecs[14];

  initial begin
    exp_t e;
    logic [31:0] ins, rvd, rva, rvb;
    int opc, r;
    logic rst;

    vecs[0]  = '{32'h0461FFFB, 32'd0, 32'd10, 32'd0, 32'd5, 1'b1, 2'b00, 1'b0};
    vecs[1]  = '{mk(1, 2, 1, 1), 32'd0, 32'h7FFFFFFF, 32'd0, 32'h80000000, 1'b1, 2'b00, 1'b0};
    vecs[2]  = '{mk(12, 2, 1, 8), 32'd7, 32'd7, 32'd0, 32'd8, 1'b0, 2'b10, 1'b0};
    vecs[3]  = '{mk(12, 2, 1, 8), 32'd7, 32'd6, 32'd0, 32'd1, 1'b0, 2'b10, 1'b0};
    vecs[4]  = '{mk(8, 3, 1, 4), 32'd0, 32'h80000000, 32'd0, 32'hF8000000, 1'b1, 2'b00, 1'b0};
    vecs[5]  = '{mk(7, 3, 1, 4), 32'd0, 32'h80000000, 32'd0, 32'h08000000, 1'b1, 2'b00, 1'b0};
    vecs[6]  = '{32'hFC000000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b1};
    vecs[7]  = '{mk(13, 2, 1, 12), 32'd5, 32'd6, 32'd0, 32'd12, 1'b0, 2'b10, 1'b0};
    vecs[8]  = '{mk(14, 31, 1, 4), 32'd0, 32'h100, 32'd0, 32'h104, 1'b1, 2'b01, 1'b0};
    vecs[9]  = '{mk(2, 4, 1, 3), 32'd0, 32'd2, 32'd0, 32'hFFFFFFFF, 1'b1, 2'b00, 1'b0};
    vecs[10] = '{mk(9, 4, 1, 16'hFFFF), 32'd0, 32'hFFFFFFFE, 32'd0, 32'd1, 1'b1, 2'b00, 1'b0};
    vecs[11] = '{mk(8, 4, 1, 40), 32'd0, 32'h80000000, 32'd0, 32'hFFFFFFFF, 1'b1, 2'b00, 1'b0};
    vecs[12] = '{mk(6, 4, 1, 40), 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 2'b00, 1'b0};
    vecs[13] = '{mk(13, 2, 1, 12), 32'd6, 32'd6, 32'd0, 32'd1, 1'b0, 2'b10, 1'b0};

    // Reset state, with a non-trivial instruction present on the inputs.
    reset = 1'b1;
    bus.instruction = 32'h0461FFFB;
    bus.rvalue_dest = 32'hDEADBEEF;
    bus.rvalue_a    = 32'h12345678;
    bus.rvalue_b    = 32'h0;
    @(posedge clock); #1;
    apply(32'h0461FFFB, 32'hDEADBEEF, 32'h12345678, 32'd0, 1'b1);
    check_all("reset", '0);

    // Directed vector table.
    foreach (vecs[i]) begin
      apply(vecs[i].ins, vecs[i].rvd, vecs[i].rva, vecs[i].rvb, 1'b0);
      chk($sformatf("vec%0d.result", i), bus.result, vecs[i].res);
      chk($sformatf("vec%0d.regbankconfig", i), {31'd0, bus.regbankconfig}, {31'd0, vecs[i].regw});
      chk($sformatf("vec%0d.pcconfig", i), {30'd0, bus.pcconfig}, {30'd0, vecs[i].pc});
      chk($sformatf("vec%0d.illegal", i), {31'd0, bus.illegal}, {31'd0, vecs[i].ill});
      if (vecs[i].ill) chk($sformatf("vec%0d.ramconfig", i), {31'd0, bus.ramconfig}, 32'd0);
      check_all($sformatf("vec%0d", i), model(vecs[i].ins, vecs[i].rvd, vecs[i].rva, vecs[i].rvb));
    end
    chk("addi.regsource", {30'd0, bus.regsource}, 32'd0);

    // Reset asserted during a store: outputs cleared, store decoded after release.
    ins = mk(11, 5, 2, 16'h0010);
    apply(mk(1, 3, 1, 16'h0007), 32'd0, 32'd9, 32'd0, 1'b0);
    chk("pre_sw.result", bus.result, 32'd16);
    apply(ins, 32'hCAFEF00D, 32'h1000, 32'd0, 1'b1);
    check_all("sw_reset", '0);
    apply(ins, 32'hCAFEF00D, 32'h1000, 32'd0, 1'b0);
    chk("sw_after.ramconfig", {31'd0, bus.ramconfig}, 32'd1);
    chk("sw_after.result", bus.result, 32'h1010);
    chk("sw_after.dest", bus.dest, 32'hCAFEF00D);
    check_all("sw_after", model(ins, 32'hCAFEF00D, 32'h1000, 32'd0));

    // Randomized stream against the reference model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r <= 14) opc = r;
      else if (r == 15) opc = 6'h3F;
      else opc = $urandom_range(15, 63);
      ins = mk(opc, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
      rvd = $urandom; rva = $urandom; rvb = $urandom;
      if ($urandom_range(0, 1) == 1) rva = rvd;
      if ($urandom_range(0, 3) == 0) rva = {$urandom_range(0, 1) == 1, 31'd0} | 32'(rva[7:0]);
      rst = ($urandom_range(0, 19) == 0);
      apply(ins, rvd, rva, rvb, rst);
      e = rst ? exp_t'('0) : model(ins, rvd, rva, rvb);
      check_all($sformatf("rnd%0d_op%0h", n, opc), e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
